uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the 1 MBaud UART receiver. Accepts the receiver's one-cycle byte-valid pulse, buffers bytes in a small FIFO, and serves them to the CPU memory-mapped I/O path through a registered read handshake. Also provides status flags, a sticky overflow flag and an interrupt request. It sits between the UART receiver and the CPU bus/interrupt controller.

## Interface
Parameters:
- FIFO_DEPTH, 16: FIFO entries; power of two, 2..256.
- TIMEOUT_CYCLES, 2000: idle cycles before the receive-timeout flag sets, equal to 4 character times at 50 clocks/bit. Only used with UART_RX_TIMEOUT_EN.

Ports (CW = $clog2(FIFO_DEPTH)+1):
- i_Clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse from the UART receiver: byte complete.
- rx_byte  in  8  received byte; valid when rx_valid=1.
- rd_req  in  1  CPU read of the data register; sampled only in S_IDLE.
- rd_data  out  8  popped byte, or 0x00 if the FIFO was empty.
- rd_valid  out  1  one-cycle pulse: rd_data is valid.
- clr_ovf  in  1  clears the sticky overflow flag.
- irq_en  in  1  interrupt enable.
- irq_thresh  in  CW  FIFO level at or above which the interrupt is raised; 0 disables the level source.
- level  out  CW  current FIFO occupancy, 0..FIFO_DEPTH.
- status  out  8  [0] not-empty, [1] full, [2] overflow, [3] timeout, [7:4] 0.
- irq  out  1  registered interrupt request (level).

## Operation
- Write path: rx_valid with FIFO not full pushes rx_byte. rx_valid with FIFO full drops the byte and sets overflow.
- Read FSM, two states:
  - S_IDLE: rd_req=1 moves the FSM to S_RESP. If not empty, the head is popped into rd_data; if empty, rd_data=0x00 and there is no pop.
  - S_RESP: rd_valid=1 for this cycle, then return to S_IDLE. rd_req is ignored in S_RESP.
- Simultaneous push and pop in one cycle:
  - Both take effect and level is unchanged.
  - If the FIFO is full, the pop frees a slot, so the push is accepted and overflow is not set.
  - If the FIFO is empty, rd_data returns 0x00 and the pushed byte stays queued.
- Overflow: sticky. clr_ovf clears it. If clr_ovf and a new overflow occur in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH. level is a CW-bit counter with no wrap, and is never greater than FIFO_DEPTH.
- irq is registered: irq_en & ((irq_thresh!=0 & level>=irq_thresh) | overflow | timeout).
- Reset mid-operation:
  - Pointers, level and flags clear and the FSM returns to S_IDLE.
  - Any pending rd_valid is lost.
  - FIFO contents are not cleared.

## Timing
- Reset values: rd_data=0x00, rd_valid=0, level=0, status=0x00, irq=0.
- Push: rx_valid at cycle N means level and status reflect the push at N+1, and irq at N+2.
- Read: rd_req at cycle N (in S_IDLE) gives rd_data and rd_valid at N+1, with level decremented at N+1. The earliest next accepted rd_req is N+2.
- rd_data holds its value until the next read response.

## Configuration
- UART_RX_TIMEOUT_EN defined:
  - The idle counter clears on any push or pop, and also while the FIFO is empty.
  - Otherwise it increments every cycle.
  - When the count reaches TIMEOUT_CYCLES-1, timeout (status[3]) sets.
  - Timeout clears on the next push or pop, or when the FIFO becomes empty.
- UART_RX_TIMEOUT_EN undefined: no counter; status[3] and the timeout term of irq are constant 0.

## Structure
- Package uart_pkg holds:
  - the read FSM state type (S_IDLE, S_RESP);
  - STATUS_* bit-index constants;
  - the default FIFO_DEPTH and TIMEOUT_CYCLES.
- Sub-module uart_rx_fifo holds:
  - synchronous storage, read/write pointers and the level counter;
  - a push/pop interface with full/empty outputs;
  - a registered pop-data output.
- uart_rx_ctrl holds the FSM, flags, timeout counter and irq logic.

## Test plan
- Basic read: push 0x41, 0x42 → level=2, status=0x01. Two reads return 0x41 then 0x42, each with a 1-cycle rd_valid. Final level=0, status=0x00.
- Overflow: push 17 bytes 0x00..0x10 at depth 16 → status=0x07, 0x10 is dropped. Reads return 0x00..0x0F. clr_ovf → status[2]=0.
- Simultaneous push and pop at full: fill 16, then assert rd_req and rx_valid(0xAA) in the same cycle → level stays 16, overflow stays 0. The 16th subsequent read returns 0xAA.
- Empty read and back-to-back rd_req: read on an empty FIFO → rd_data=0x00, rd_valid=1, level=0. rd_req held high for 4 cycles → exactly 2 rd_valid pulses.
- Interrupt: irq_thresh=4, irq_en=1, push 4 bytes → irq=1 two cycles after the 4th push. One read → irq=0. irq_en=0 masks all sources.
- Timeout and reset (UART_RX_TIMEOUT_EN defined):
  - Push 1 byte and idle → status[3]=1 exactly TIMEOUT_CYCLES cycles after the push; clears on the read.
  - Assert reset_n low mid-read → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, status bit positions and default sizing for the UART receive controller.
package uart_pkg;
    typedef enum logic {S_IDLE, S_RESP} rd_state_e;
    localparam int STATUS_NE = 0;
    localparam int STATUS_FULL = 1;
    localparam int STATUS_OVF = 2;
    localparam int STATUS_TMO = 3;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT_CYCLES = 2000;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver byte input, CPU read handshake, status and interrupt signals.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rd_req;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          clr_ovf;
    logic          irq_en;
    logic [CW-1:0] irq_thresh;
    logic [CW-1:0] level;
    logic [7:0]    status;
    logic          irq;
    modport slave (
        input  rx_valid, rx_byte, rd_req, clr_ovf, irq_en, irq_thresh,
        output rd_data, rd_valid, level, status, irq
    );
    modport master (
        output rx_valid, rx_byte, rd_req, clr_ovf, irq_en, irq_thresh,
        input  rd_data, rd_valid, level, status, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO with accepted-strobe outputs and a registered pop-data port.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          push_ok_o,
    output logic          pop_ok_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] level_q, level_d;
    logic [7:0]    data_q, data_d;
    assign empty_o   = level_q == '0;
    assign full_o    = level_q == CW'(DEPTH);
    assign pop_ok_o  = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok_o = push_i & (~full_o | pop_ok_o);
    assign data_o    = data_q;
    assign level_o   = level_q;
    always_comb begin
        level_d = level_q + CW'(push_ok_o) - CW'(pop_ok_o);
        data_d  = pop_i ? (empty_o ? 8'h00 : mem_q[rptr_q]) : data_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(push_ok_o);
            rptr_q  <= rptr_q + AW'(pop_ok_o);
            level_q <= level_d;
            data_q  <= data_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: buffers UART receive bytes and serves them over a registered CPU read handshake.
// Optional receive-timeout flag enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           i_Clock,
    input  logic           reset_n,
    uart_rx_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    rd_state_e     state_q, state_d;
    logic          rd_accept, push_ok, pop_ok, full, empty;
    logic          ovf_q, ovf_d, irq_q, irq_d, tmo_q;
    logic [CW-1:0] level;
    logic [7:0]    status;
    assign rd_accept = (state_q == S_IDLE) & bus.rd_req;
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (i_Clock),
        .rst_ni    (reset_n),
        .push_i    (bus.rx_valid),
        .data_i    (bus.rx_byte),
        .pop_i     (rd_accept),
        .data_o    (bus.rd_data),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );
    always_comb begin
        state_d = S_IDLE;
        if (state_q == S_IDLE) state_d = bus.rd_req ? S_RESP : S_IDLE;
    end
    always_comb begin
        // a dropped byte wins over a simultaneous clear
        ovf_d = (bus.rx_valid & ~push_ok) ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
        irq_d = bus.irq_en & (((bus.irq_thresh != '0) & (level >= bus.irq_thresh)) | ovf_q | tmo_q);
        status = '0;
        status[STATUS_NE]   = ~empty;
        status[STATUS_FULL] = full;
        status[STATUS_OVF]  = ovf_q;
        status[STATUS_TMO]  = tmo_q;
    end
    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end
`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tmo_d, idle_clr;
    // counter saturates at the terminal count so the flag stays set while idle
    always_comb begin
        idle_clr = push_ok | pop_ok | empty;
        cnt_d = idle_clr ? '0 : ((cnt_q == TMO_LAST) ? cnt_q : cnt_q + 1'b1);
        tmo_d = idle_clr ? 1'b0 : ((cnt_d == TMO_LAST) ? 1'b1 : tmo_q);
    end
    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_q = 1'b0;
`endif
    assign bus.rd_valid = state_q == S_RESP;
    assign bus.level    = level;
    assign bus.status   = status;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;
    import uart_pkg::*;
    localparam int D  = 16;
    localparam int CW = $clog2(D) + 1;
    localparam int T  = DEF_TIMEOUT_CYCLES;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    always #5 clk = ~clk;
    uart_rx_ctrl_if #(.FIFO_DEPTH(D)) bus ();
    uart_rx_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .i_Clock (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
        if (mq.size() < D) mq.push_back(b);
    endtask
    task automatic do_read(input string tag);
        int n;
        logic [7:0] e;
        if (mq.size() != 0) exp_q.push_back(mq.pop_front());
        else exp_q.push_back(8'h00);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        n = 0;
        while (!bus.rd_valid && n < 4) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, bus.rd_valid, 1);
        e = exp_q.pop_front();
        chk({tag, "_data"}, bus.rd_data, e);
        tick();
        chk({tag, "_pulse"}, bus.rd_valid, 0);
    endtask
    initial begin
        int pulses;
        bus.rx_valid = 0; bus.rx_byte = 0; bus.rd_req = 0; bus.clr_ovf = 0;
        bus.irq_en = 0; bus.irq_thresh = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_status", bus.status, 0);
        chk("rst_irq", bus.irq, 0);
        push(8'h41);
        push(8'h42);
        chk("basic_level", bus.level, 2);
        chk("basic_status", bus.status, 8'h01);
        do_read("basic_rd0");
        do_read("basic_rd1");
        chk("basic_level_end", bus.level, 0);
        chk("basic_status_end", bus.status, 0);
        for (int i = 0; i <= 16; i++) push(8'(i));
        chk("ovf_status", bus.status, 8'h07);
        chk("ovf_level", bus.level, D);
        for (int i = 0; i < D; i++) do_read("ovf_rd");
        chk("ovf_drained", bus.status, 8'h04);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("ovf_clear", bus.status, 8'h00);
        for (int i = 0; i < D; i++) push(8'h80 + 8'(i));
        chk("sim_full_status", bus.status, 8'h03);
        exp_q.push_back(mq.pop_front());
        mq.push_back(8'hAA);
        bus.rd_req = 1'b1; bus.rx_valid = 1'b1; bus.rx_byte = 8'hAA;
        tick();
        bus.rd_req = 1'b0; bus.rx_valid = 1'b0;
        chk("sim_valid", bus.rd_valid, 1);
        chk("sim_data", bus.rd_data, exp_q.pop_front());
        chk("sim_level", bus.level, D);
        chk("sim_status", bus.status, 8'h03);
        tick();
        for (int i = 0; i < D; i++) do_read("sim_rd");
        chk("sim_level_end", bus.level, 0);
        do_read("empty_rd");
        chk("empty_level", bus.level, 0);
        pulses = 0;
        bus.rd_req = 1'b1;
        repeat (4) begin
            tick();
            if (bus.rd_valid) begin
                pulses++;
                chk("b2b_data", bus.rd_data, 0);
            end
        end
        bus.rd_req = 1'b0;
        tick();
        if (bus.rd_valid) pulses++;
        chk("b2b_pulses", pulses, 2);
        bus.irq_thresh = CW'(4);
        bus.irq_en = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("irq_n1", bus.irq, 0);
        tick();
        chk("irq_n2", bus.irq, 1);
        do_read("irq_rd");
        chk("irq_after_rd", bus.irq, 0);
        bus.irq_en = 1'b0;
        for (int i = 0; i < 14; i++) push(8'h10 + 8'(i));
        tick();
        tick();
        chk("irq_masked", bus.irq, 0);
        chk("irq_mask_status", bus.status, 8'h07);
        bus.irq_en = 1'b1;
        tick();
        tick();
        chk("irq_unmasked", bus.irq, 1);
        bus.irq_en = 1'b0;
        bus.irq_thresh = '0;
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        while (mq.size() != 0) do_read("irq_drain");
        chk("irq_drain_level", bus.level, 0);
`ifdef UART_RX_TIMEOUT_EN
        push(8'h77);
        repeat (T - 2) tick();
        chk("tmo_early", bus.status[STATUS_TMO], 0);
        tick();
        chk("tmo_set", bus.status[STATUS_TMO], 1);
        do_read("tmo_rd");
        chk("tmo_clear", bus.status, 8'h00);
`endif
        bus.irq_en = 1'b1;
        bus.irq_thresh = CW'(1);
        push(8'h5A);
        tick();
        chk("rstm_irq", bus.irq, 1);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk("rstm_valid", bus.rd_valid, 1);
        chk("rstm_data", bus.rd_data, mq.pop_front());
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_rd_data", bus.rd_data, 0);
        chk("rstm_rd_valid", bus.rd_valid, 0);
        chk("rstm_level", bus.level, 0);
        chk("rstm_status", bus.status, 0);
        chk("rstm_irq", bus.irq, 0);
        bus.irq_en = 1'b0;
        bus.irq_thresh = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_level", bus.level, 0);
        chk("post_rst_valid", bus.rd_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
